wptr_ctrl: RTL
==============

# wptr_ctrl

Write-domain pointer and flag controller for the asynchronous FIFO, parametrised in depth, with registered binary fill level, programmable almost-full threshold and optional sticky overflow detection. It sits in the `wclk` domain between the write client and the dual-port RAM. It consumes the read pointer after the two-flop Gray synchroniser. It drives the RAM write address/enable and the Gray write pointer that crosses to the read domain.

## Interface
Parameters:
- `ADDR_W`, default 9: RAM address width; depth = 2^ADDR_W; legal range ≥ 2.

Ports:
- `wclk`  in  1  write clock.
- `wrst`  in  1  reset, asynchronous, active-low.
- `winc`  in  1  write request from client.
- `rptr_s`  in  ADDR_W+1  Gray read pointer, already synchronised into `wclk`.
- `afull_thresh`  in  ADDR_W+1  almost-full threshold in entries; 0 disables.
- `ovf_clr`  in  1  clears sticky overflow.
- `wen`  out  1  RAM write enable, combinational: `winc & ~full`.
- `wr_addr`  out  ADDR_W  RAM write address: binary pointer LSBs.
- `wptr`  out  ADDR_W+1  registered Gray write pointer to the read-domain synchroniser.
- `full`  out  1  registered full flag.
- `afull`  out  1  registered almost-full flag.
- `wlevel`  out  ADDR_W+1  registered occupancy, range 0..2^ADDR_W.
- `overflow`  out  1  sticky: write attempted while full.

## Operation
- Internal binary pointer `wbin` is ADDR_W+1 bits. `wbin_nxt = wbin + wen`, which wraps modulo 2^(ADDR_W+1). `wgray_nxt = (wbin_nxt>>1) ^ wbin_nxt`.
- `rbin = gray2bin(rptr_s)`.
- `level_nxt = wbin_nxt - rbin`, computed modulo 2^(ADDR_W+1). Level arithmetic is in binary only, never on Gray codes.
- `full_nxt = (wgray_nxt == {~rptr_s[ADDR_W:ADDR_W-1], rptr_s[ADDR_W-2:0]})`. This is equivalent to `level_nxt == 2^ADDR_W`.
- `afull_nxt = (afull_thresh != 0) && (level_nxt >= afull_thresh)`. A threshold above 2^ADDR_W never asserts.
- Writes while `full` are dropped: `wen` = 0, pointer holds.
- On every `wclk` edge, `wbin`, `wptr`, `full`, `afull` and `wlevel` load their `_nxt` values.
- Reset (`wrst` low, at any time including mid-burst): `wbin`, `wptr`, `wr_addr`, `wlevel`, `full`, `afull` and `overflow` all go to 0 immediately. Release is synchronous to the next `wclk` edge.

## Timing
- Write latency: `wen` and `wr_addr` are valid in the cycle `winc` is presented; the RAM captures on that edge.
- `full`, `afull` and `wlevel` reflect the write accepted on the same edge. After the edge that accepts the 2^ADDR_W-th outstanding write, `full` = 1 with no extra cycle.
- Deassertion of `full`, `afull` and `wlevel` lags reads by the synchroniser latency (2 `wclk` cycles plus 1 register). This is pessimistic and safe.
- Simultaneous `winc` with a read-pointer advance: the level is computed from both `wbin_nxt` and the current `rptr_s`.
- `wptr` changes by at most one bit per cycle.

## Configuration
- `WPTR_OVF_EN` defined:
  - `overflow` sets on any edge with `winc & full`.
  - `overflow` clears on `ovf_clr`.
  - If both occur on the same edge, set wins.
- `WPTR_OVF_EN` undefined: `overflow` is tied 0, `ovf_clr` is ignored, and no flop is inferred.

## Structure
- Package `fifo_pkg`:
  - `ADDR_W` default constant.
  - Typedef for pointer width.
  - Functions `bin2gray` and `gray2bin`, shared with the read-side controller.
- One sub-module, `gray2bin`: a parametrised XOR-prefix converter of width ADDR_W+1, instantiated for `rptr_s`.

## Test plan
- Reset, `ADDR_W`=9, `rptr_s`=0, 512 consecutive writes:
  - after write 511, `full`=0 and `wlevel`=511;
  - after write 512, `full`=1, `wlevel`=512, `wr_addr`=0 and `wptr`=10'b1100000000.
- Full, `winc` held 3 cycles: `wen`=0, pointers unchanged, `overflow`=1. Then `ovf_clr` for 1 cycle → `overflow`=0. With `WPTR_OVF_EN` undefined → `overflow` stays 0.
- `afull_thresh`=500: `afull` rises on the edge of write 500. With `afull_thresh`=0 → `afull` never asserts.
- Wrap-around: stream 2000 writes with `rptr_s` following the Gray-encoded write pointer delayed by 3 cycles. Required: `wlevel` never exceeds 512, `full` is never falsely set, and `wptr` Hamming distance between cycles is ≤ 1.
- Assert `wrst` mid-burst at `wlevel`=300: all outputs are 0 asynchronously. The first write after release uses `wr_addr`=0.
- Simultaneous write and read at `wlevel`=512→511: `full` drops once the synchronised read arrives, the same-cycle write is accepted, and `full` returns to 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width, pointer type and Gray helpers.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

    localparam int FIFO_ADDR_W = 9;

    typedef logic [FIFO_ADDR_W:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        for (int i = 0; i <= FIFO_ADDR_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Gray-to-binary converter of parametrised width (XOR prefix from the MSB down).
// Latency: purely combinational; backpressure: none.
module gray2bin #(
    parameter int W = 10
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_ctrl.sv
// Write-domain pointer/flag controller for the async FIFO; sticky overflow built when WPTR_OVF_EN is defined.
// Latency: wen/wr_addr combinational with winc; wptr, full, afull, wlevel registered on the accepting edge.
// Backpressure: writes presented while full are dropped (wen low, pointer holds); flag release lags reads via the synchroniser.
module wptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              winc,
    input  logic [ADDR_W:0]   rptr_s,
    input  logic [ADDR_W:0]   afull_thresh,
    input  logic              ovf_clr,
    output logic              wen,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   wptr,
    output logic              full,
    output logic              afull,
    output logic [ADDR_W:0]   wlevel,
    output logic              overflow
);

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_nxt;
    logic [ADDR_W:0] wgray_nxt;
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] level_nxt;
    logic            full_nxt;
    logic            afull_nxt;

    gray2bin #(
        .W (ADDR_W + 1)
    ) u_rbin (
        .gray (rptr_s),
        .bin  (rbin)
    );

    assign wen       = winc & ~full;
    assign wr_addr   = wbin[ADDR_W-1:0];
    assign wbin_nxt  = wbin + {{ADDR_W{1'b0}}, wen};
    assign wgray_nxt = (wbin_nxt >> 1) ^ wbin_nxt;

    // Occupancy in binary; modulo wrap of the extra MSB keeps it in 0..2^ADDR_W.
    assign level_nxt = wbin_nxt - rbin;

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_nxt  = (wgray_nxt == {~rptr_s[ADDR_W:ADDR_W-1], rptr_s[ADDR_W-2:0]});
    assign afull_nxt = (afull_thresh != '0) && (level_nxt >= afull_thresh);

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            wbin   <= '0;
            wptr   <= '0;
            wlevel <= '0;
            full   <= 1'b0;
            afull  <= 1'b0;
        end else begin
            wbin   <= wbin_nxt;
            wptr   <= wgray_nxt;
            wlevel <= level_nxt;
            full   <= full_nxt;
            afull  <= afull_nxt;
        end
    end

`ifdef WPTR_OVF_EN
    logic ovf_q;

    // A dropped write on the same edge as a clear keeps the flag set.
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            ovf_q <= 1'b0;
        end else if (winc & full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule
